cflog_slice_scheduler: RTL and testbench
========================================

CFLOG_SLICE_SCHEDULER -- requirements
Module: cflog_slice_scheduler

Interface
REQ-001 Parameter LOG_SIZE, default 16'h0100, is the CFLog capacity in bytes; the entry pointer wraps to 0 at LOG_SIZE.
REQ-002 Parameter SLICE_SIZE, default 16'h0020, is the number of bytes per transmitted slice; it SHALL be even and SHALL divide LOG_SIZE.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 hw_wr_en  in  1  logger write strobe for the current cycle.
REQ-006 cflow_log_ptr  in  16  logger byte pointer; the next free entry, even-aligned.
REQ-007 hw_wr_data  in  16  logger entry data, valid when hw_wr_en=1.
REQ-008 flush  in  1  level signal from the logger: drain all entries between top_slice and cflow_log_ptr.
REQ-009 mem_en / mem_wr  out  1 / 1  single-port CFLog RAM enable and write select.
REQ-010 mem_addr / mem_wdata  out  16 / 16  RAM byte address and write data.
REQ-011 mem_rdata  in  16  RAM read data, valid exactly 1 cycle after the read is issued.
REQ-012 tx_valid / tx_data / tx_last  out  1 / 16 / 1  transmit stream toward the attestation channel.
REQ-013 tx_ready  in  1  transmit sink accepts the word when tx_valid && tx_ready.
REQ-014 top_slice  out  16  byte address of the oldest unsent entry; fed back to the logger.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The RAM port SHALL be shared between logger writes and scheduler reads; hw_wr_en SHALL have absolute priority.
REQ-017 When hw_wr_en=1, the same-cycle outputs SHALL be mem_en=1, mem_wr=1, mem_addr=cflow_log_ptr, and mem_wdata=hw_wr_data, combinationally.
REQ-018 pending SHALL be computed as (cflow_log_ptr - top_slice) mod LOG_SIZE, using 16-bit arithmetic corrected by adding LOG_SIZE on underflow.
REQ-019 FSM states: IDLE, RD, WT, SEND, plus CRC when the configuration macro is defined.
REQ-020 IDLE->RD SHALL occur when pending >= SLICE_SIZE, or when flush=1 and pending != 0; slice_len SHALL latch min(pending, SLICE_SIZE) at that time.
REQ-021 In RD, if hw_wr_en=0, the block SHALL drive mem_en=1, mem_wr=0, mem_addr=rd_ptr and go to WT; otherwise it SHALL hold in RD (deferred read).
REQ-022 rd_ptr SHALL be top_slice on slice start and SHALL advance by 2 per accepted word, wrapping from LOG_SIZE-2 to 0.
REQ-023 In WT, mem_rdata SHALL be captured into tx_data, tx_valid SHALL be set, and the FSM SHALL go to SEND; a logger write in WT SHALL NOT corrupt the capture.
REQ-024 In SEND, tx_valid and tx_data SHALL be held stable until tx_ready=1.
REQ-025 On acceptance in SEND: top_slice SHALL advance by 2 (wrapping), the byte count SHALL increment by 2, and the FSM SHALL go to RD, or end the slice when count reaches slice_len.
REQ-026 tx_last SHALL be 1 on the final word of a slice (the CRC word when enabled), and 0 otherwise.
REQ-027 Slice end SHALL return the FSM to IDLE; a new slice MAY start on the next cycle.
REQ-028 top_slice SHALL never pass cflow_log_ptr; if pending=0 mid-slice (pointer anomaly), the slice SHALL terminate with tx_last on the current word.
REQ-029 Deasserting flush mid-slice SHALL NOT shorten the latched slice_len.

Reset
REQ-030 reset=1 SHALL force IDLE and clear top_slice, rd_ptr, count, and slice_len to 0.
REQ-031 reset=1 SHALL clear tx_valid, tx_last, tx_data, and busy to 0.
REQ-032 reset=1 SHALL clear mem_en and mem_wr to 0 unless hw_wr_en=1.
REQ-033 Reset mid-slice SHALL abandon the slice without asserting tx_last.

Configuration
REQ-034 With CFLOG_SLICE_CRC_EN defined, the block SHALL accumulate the 16-bit sum mod 2^16 of each slice's data words.
REQ-035 With CFLOG_SLICE_CRC_EN defined, after the last data word is accepted, the block SHALL send that sum in state CRC as one extra word with tx_last=1; the sum SHALL then clear, and top_slice SHALL NOT advance for it.
REQ-036 Without CFLOG_SLICE_CRC_EN, the CRC state and accumulator SHALL be absent, and tx_last SHALL mark the last data word.

Verification
REQ-037 Logger writes 16 words 0x0001..0x0010 at ptr 0..0x1E, with tx_ready=1 -> one slice of 16 words, tx_last on the 16th, top_slice=0x20, busy low after.
REQ-038 hw_wr_en=1 on every cycle the FSM is in RD -> the read stalls; no mem read is issued during any write cycle; data order is unchanged.
REQ-039 ptr=0x06, flush=1 -> 3 words sent, tx_last on the 3rd, top_slice=0x06.
REQ-040 top_slice=0xF0, ptr=0x10 (wrapped) -> pending=0x20; the slice reads 0xF0..0xFE then 0x00..0x0E; top_slice=0x10.
REQ-041 tx_ready held low for 10 cycles mid-slice -> tx_valid and tx_data are stable throughout; reset asserted in SEND -> all outputs 0 on the next cycle.
REQ-042 With CFLOG_SLICE_CRC_EN defined, words 0xFFFF and 0x0002 with flush -> a 3rd word 0x0001 with tx_last=1.

Source files
------------

// File: rtl/cflog_slice_scheduler_if.sv
// Bundle of logger, CFLog RAM and transmit-stream signals around the slice scheduler.
// master: the scheduler side; slave: the logger / RAM / transmit-sink side.
interface cflog_slice_scheduler_if;
    logic        hw_wr_en;
    logic [15:0] cflow_log_ptr;
    logic [15:0] hw_wr_data;
    logic        flush;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_last;
    logic        tx_ready;
    logic [15:0] top_slice;
    logic        busy;

    modport master (
        input  hw_wr_en, cflow_log_ptr, hw_wr_data, flush, mem_rdata, tx_ready,
        output mem_en, mem_wr, mem_addr, mem_wdata, tx_valid, tx_data, tx_last,
        output top_slice, busy
    );

    modport slave (
        output hw_wr_en, cflow_log_ptr, hw_wr_data, flush, mem_rdata, tx_ready,
        input  mem_en, mem_wr, mem_addr, mem_wdata, tx_valid, tx_data, tx_last,
        input  top_slice, busy
    );
endinterface

// File: rtl/cflog_slice_scheduler.sv
// Drains the CFLog ring buffer in fixed-size slices onto a valid/ready stream.
// Optional macro CFLOG_SLICE_CRC_EN appends a 16-bit word-sum trailer to each slice.
module cflog_slice_scheduler #(
    parameter logic [15:0] LOG_SIZE   = 16'h0100,
    parameter logic [15:0] SLICE_SIZE = 16'h0020
) (
    input  logic                          clk,
    input  logic                          reset,
    cflog_slice_scheduler_if.master       bus
);

`ifdef CFLOG_SLICE_CRC_EN
    typedef enum logic [2:0] {IDLE, RD, WT, SEND, CRC} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, WT, SEND} state_t;
`endif

    state_t      state;
    logic [15:0] top_q;
    logic [15:0] rd_ptr;
    logic [15:0] count;
    logic [15:0] slice_len;
    logic [15:0] tx_data_q;
    logic        tx_valid_q;
    logic        tx_last_q;
    logic        last_word;
    logic [15:0] pending;
    logic        slice_start;
    logic [15:0] next_len;
    logic        at_end;
`ifdef CFLOG_SLICE_CRC_EN
    logic [15:0] crc_sum;
`endif

    function automatic logic [15:0] wrap_inc(input logic [15:0] a);
        return (a >= LOG_SIZE - 16'd2) ? 16'd0 : a + 16'd2;
    endfunction

    function automatic logic [15:0] ring_dist(input logic [15:0] head, input logic [15:0] tail);
        logic [15:0] d;
        d = head - tail;
        if (head < tail)
            d = d + LOG_SIZE;
        return d;
    endfunction

    always_comb begin
        pending     = ring_dist(bus.cflow_log_ptr, top_q);
        slice_start = (pending >= SLICE_SIZE) || (bus.flush && (pending != 16'd0));
        next_len    = (pending >= SLICE_SIZE) ? SLICE_SIZE : pending;
        // pending still counts the word being captured, so <=2 means nothing lies beyond it
        at_end      = ((count + 16'd2) >= slice_len) || (pending <= 16'd2);
    end

    // Logger writes always win the shared RAM port; reads only go out from RD.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 16'd0;
        bus.mem_wdata = 16'd0;
        if (bus.hw_wr_en) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = bus.cflow_log_ptr;
            bus.mem_wdata = bus.hw_wr_data;
        end else if ((state == RD) && !reset) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = rd_ptr;
        end
    end

    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_last   = tx_last_q;
    assign bus.top_slice = top_q;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            top_q      <= 16'd0;
            rd_ptr     <= 16'd0;
            count      <= 16'd0;
            slice_len  <= 16'd0;
            tx_data_q  <= 16'd0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            last_word  <= 1'b0;
`ifdef CFLOG_SLICE_CRC_EN
            crc_sum    <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (slice_start) begin
                        slice_len <= next_len;
                        rd_ptr    <= top_q;
                        count     <= 16'd0;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (!bus.hw_wr_en)
                        state <= WT;
                end
                WT: begin
                    tx_data_q  <= bus.mem_rdata;
                    tx_valid_q <= 1'b1;
                    last_word  <= at_end;
`ifdef CFLOG_SLICE_CRC_EN
                    tx_last_q  <= 1'b0;
`else
                    tx_last_q  <= at_end;
`endif
                    state      <= SEND;
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (pending != 16'd0)
                            top_q <= wrap_inc(top_q);
                        rd_ptr <= wrap_inc(rd_ptr);
                        count  <= count + 16'd2;
`ifdef CFLOG_SLICE_CRC_EN
                        crc_sum <= crc_sum + tx_data_q;
                        if (last_word) begin
                            tx_data_q <= crc_sum + tx_data_q;
                            tx_last_q <= 1'b1;
                            state     <= CRC;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state      <= RD;
                        end
`else
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        state      <= last_word ? IDLE : RD;
`endif
                    end
                end
`ifdef CFLOG_SLICE_CRC_EN
                CRC: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        crc_sum    <= 16'd0;
                        state      <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cflog_slice_scheduler.sv
// Scoreboard bench for cflog_slice_scheduler: logger and RAM models drive the DUT,
// expected stream words and read addresses are queued when writes are issued.
module tb_cflog_slice_scheduler;
    logic clk = 1'b0;
    logic reset;

    cflog_slice_scheduler_if bus();

    cflog_slice_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:127];
    logic [15:0] exp_d [$];
    logic        exp_l [$];
    logic [15:0] exp_a [$];
    logic [15:0] crc_model;
    logic [15:0] ptr;
    int          n_chk;
    int          n_fail;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wr)
                ram[bus.mem_addr[7:1]] <= bus.mem_wdata;
            else
                bus.mem_rdata <= ram[bus.mem_addr[7:1]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.hw_wr_en) begin
                check_val("wr_sel", {bus.mem_en, bus.mem_wr}, 32'd3);
                check_val("wr_addr", bus.mem_addr, bus.cflow_log_ptr);
                check_val("wr_data", bus.mem_wdata, bus.hw_wr_data);
            end else if (bus.mem_en && !bus.mem_wr) begin
                if (exp_a.size() == 0)
                    check_val("rd_unexpected", bus.mem_addr, 32'hFFFF_FFFF);
                else
                    check_val("rd_addr", bus.mem_addr, exp_a.pop_front());
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_d.size() == 0)
                    check_val("tx_unexpected", bus.tx_data, 32'hFFFF_FFFF);
                else begin
                    check_val("tx_data", bus.tx_data, exp_d.pop_front());
                    check_val("tx_last", bus.tx_last, exp_l.pop_front());
                end
            end
        end
    end

    function automatic logic [15:0] next_ptr(input logic [15:0] p);
        return (p >= 16'h00FE) ? 16'h0000 : p + 16'd2;
    endfunction

    task automatic push_word(input logic [15:0] d, input logic end_slice, input logic [15:0] addr);
        exp_a.push_back(addr);
`ifdef CFLOG_SLICE_CRC_EN
        exp_d.push_back(d);
        exp_l.push_back(1'b0);
        crc_model = crc_model + d;
        if (end_slice) begin
            exp_d.push_back(crc_model);
            exp_l.push_back(1'b1);
            crc_model = 16'd0;
        end
`else
        exp_d.push_back(d);
        exp_l.push_back(end_slice);
`endif
    endtask

    // Entered and left at posedge+1 so consecutive calls write back-to-back.
    task automatic log_write(input logic [15:0] d);
        bus.hw_wr_en      = 1'b1;
        bus.cflow_log_ptr = ptr;
        bus.hw_wr_data    = d;
        @(posedge clk);
        #1;
        ptr               = next_ptr(ptr);
        bus.cflow_log_ptr = ptr;
        bus.hw_wr_en      = 1'b0;
    endtask

    task automatic write_words(input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            int          sz;
            logic [15:0] d;
            sz = ((n - (k / 16) * 16) >= 16) ? 16 : n - (k / 16) * 16;
            d  = base + 16'(k);
            push_word(d, (k % 16) == (sz - 1), ptr);
            log_write(d);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_d.size() == 0 && !bus.busy)
                done = 1'b1;
        end
        if (!done) begin
            check_val("drain_left", exp_d.size(), 32'd0);
            check_val("drain_busy", bus.busy, 32'd0);
            exp_d.delete();
            exp_l.delete();
            exp_a.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finish_block(input int n);
        if ((n % 16) != 0) begin
            bus.flush = 1'b1;
            drain();
            bus.flush = 1'b0;
        end else begin
            drain();
        end
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_valid)
                seen = 1'b1;
        end
        if (!seen)
            check_val("valid_timeout", bus.tx_valid, 32'd1);
    endtask

    initial begin
        n_chk             = 0;
        n_fail            = 0;
        ptr               = 16'd0;
        crc_model         = 16'd0;
        reset             = 1'b1;
        bus.hw_wr_en      = 1'b0;
        bus.cflow_log_ptr = 16'd0;
        bus.hw_wr_data    = 16'd0;
        bus.flush         = 1'b0;
        bus.tx_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_top", bus.top_slice, 32'd0);
        check_val("rst_busy", bus.busy, 32'd0);
        check_val("rst_valid", bus.tx_valid, 32'd0);
        check_val("rst_last", bus.tx_last, 32'd0);
        check_val("rst_data", bus.tx_data, 32'd0);
        check_val("rst_mem", {bus.mem_en, bus.mem_wr}, 32'd0);

        // One full slice of 0x0001..0x0010.
        write_words(16, 16'h0001);
        finish_block(16);
        check_val("s1_top", bus.top_slice, 32'h20);
        check_val("s1_busy", bus.busy, 32'd0);

        // Continuous logger writes keep the first slice stalled in RD.
        write_words(32, 16'h0100);
        finish_block(32);
        check_val("stall_top", bus.top_slice, 32'h60);

        // Short flushed slice; flush drops right after the slice starts.
        write_words(3, 16'h0050);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        drain();
        check_val("flush_top", bus.top_slice, 32'h66);

        // Back-pressure: word must hold for 10 cycles.
        bus.tx_ready = 1'b0;
        write_words(16, 16'h0A00);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("hold_valid", bus.tx_valid, 32'd1);
            check_val("hold_data", bus.tx_data, exp_d[0]);
        end
        bus.tx_ready = 1'b1;
        drain();
        check_val("bp_top", bus.top_slice, 32'h86);

        // Reset while a word waits in SEND.
        bus.tx_ready = 1'b0;
        write_words(16, 16'h0600);
        wait_valid();
        @(posedge clk);
        #1;
        reset             = 1'b1;
        ptr               = 16'd0;
        bus.cflow_log_ptr = 16'd0;
        exp_d.delete();
        exp_l.delete();
        exp_a.delete();
        crc_model = 16'd0;
        @(posedge clk);
        #1;
        check_val("mid_rst_valid", bus.tx_valid, 32'd0);
        check_val("mid_rst_last", bus.tx_last, 32'd0);
        check_val("mid_rst_data", bus.tx_data, 32'd0);
        check_val("mid_rst_busy", bus.busy, 32'd0);
        check_val("mid_rst_top", bus.top_slice, 32'd0);
        check_val("mid_rst_mem", {bus.mem_en, bus.mem_wr}, 32'd0);
        reset        = 1'b0;
        bus.tx_ready = 1'b1;

        // Walk the buffer up to 0xF0, then a slice that wraps to 0x10.
        write_words(120, 16'h1000);
        finish_block(120);
        check_val("fill_top", bus.top_slice, 32'hF0);
        write_words(16, 16'h2000);
        finish_block(16);
        check_val("wrap_top", bus.top_slice, 32'h10);

`ifdef CFLOG_SLICE_CRC_EN
        exp_a.push_back(ptr);
        exp_d.push_back(16'hFFFF);
        exp_l.push_back(1'b0);
        log_write(16'hFFFF);
        exp_a.push_back(ptr);
        exp_d.push_back(16'h0002);
        exp_l.push_back(1'b0);
        log_write(16'h0002);
        exp_d.push_back(16'h0001);
        exp_l.push_back(1'b1);
        bus.flush = 1'b1;
        drain();
        bus.flush = 1'b0;
        check_val("crc_top", bus.top_slice, 32'h14);
`endif

        check_val("end_queue", exp_d.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
